// File: rtl/wb_display7seg_pkg.sv
// Shared constants for the Wishbone 7-segment display controller:
// register offsets, CTRL layout/reset value and the hex segment table.
package wb_display7seg_pkg;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_CTRL   = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;

  localparam int         CTRL_W         = 5;
  localparam int         CTRL_BLANK_BIT = 4;
  localparam logic [4:0] CTRL_RESET     = 5'h0F;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segments, bit6 = a ... bit0 = g, indexed by nibble value.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

endpackage

// File: rtl/wb_display7seg_decode.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg7_hex_decode
  import wb_display7seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup of the segment pattern for the nibble.
  always_comb begin
    seg = SEG_TABLE[nibble];
  end

endmodule

// File: rtl/wb_display7seg.sv
// Wishbone slave driving a 4-digit multiplexed 7-segment display.
// DATA holds four hex nibbles, CTRL holds a per-digit enable mask and a
// blank-all bit, STATUS exposes the digit currently being scanned.
module wb_display7seg
  import wb_display7seg_pkg::*;
#(
  parameter int CLK_DIV = 50000
) (
  input  logic        clk_in_1,
  input  logic        reset,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  output logic [6:0]  segments,
  output logic [3:0]  catodo
);

  localparam int              CNT_W  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0]  prescale;
  logic [1:0]        digit;
  logic [15:0]       data_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic              ack_q;
  logic              req;
  logic              wrap;
  logic [1:0]        offset;
  logic [31:0]       rdata;
  logic [3:0]        nibble;
  logic [6:0]        dec_seg;
  logic              digit_on;
  logic              unused_ok;

  assign unused_ok = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:16], wb_sel_i[3:2]};

  assign req      = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wrap     = (prescale == CNT_TC);
  assign offset   = wb_adr_i[3:2];
  assign wb_ack_o = ack_q;

  // Prescaler runs continuously; each wrap advances the scanned digit.
  always_ff @(posedge clk_in_1 or posedge reset) begin
    if (reset) begin
      prescale <= '0;
      digit    <= 2'd0;
    end else if (wrap) begin
      prescale <= '0;
      digit    <= digit + 2'd1;
    end else begin
      prescale <= prescale + 1'b1;
    end
  end

  // Register file writes, byte lanes gated by wb_sel_i.
  always_ff @(posedge clk_in_1 or posedge reset) begin
    if (reset) begin
      data_q <= 16'h0000;
      ctrl_q <= CTRL_RESET;
    end else if (req && wb_we_i) begin
      if (offset == OFF_DATA) begin
        if (wb_sel_i[0]) data_q[7:0]  <= wb_dat_i[7:0];
        if (wb_sel_i[1]) data_q[15:8] <= wb_dat_i[15:8];
      end else if (offset == OFF_CTRL) begin
        if (wb_sel_i[0]) ctrl_q <= wb_dat_i[CTRL_W-1:0];
      end
    end
  end

  // Read mux; unmapped offset returns zero.
  always_comb begin
    rdata = 32'h0;
    case (offset)
      OFF_DATA:   rdata = {16'h0, data_q};
      OFF_CTRL:   rdata = {{(32-CTRL_W){1'b0}}, ctrl_q};
      OFF_STATUS: rdata = {30'h0, digit};
      default:    rdata = 32'h0;
    endcase
  end

  // Single-cycle ack per request; read data captured on the acking edge.
  always_ff @(posedge clk_in_1 or posedge reset) begin
    if (reset) begin
      ack_q    <= 1'b0;
      wb_dat_o <= 32'h0;
    end else begin
      ack_q <= req;
      if (req && !wb_we_i) wb_dat_o <= rdata;
    end
  end

  assign nibble   = data_q[{digit, 2'b00} +: 4];
  assign digit_on = ctrl_q[digit] & ~ctrl_q[CTRL_BLANK_BIT];

  seg7_hex_decode u_decode (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  // ---- output stage: registered segment and digit-select drive ----
  always_ff @(posedge clk_in_1 or posedge reset) begin
    if (reset) begin
      segments <= SEG_BLANK;
      catodo   <= 4'b1111;
    end else if (digit_on) begin
      segments <= dec_seg;
      catodo   <= ~(4'b0001 << digit);
    end else begin
      segments <= SEG_BLANK;
      catodo   <= 4'b1111;
    end
  end

endmodule

// File: tb/tb_wb_display7seg.sv
// Directed bench for wb_display7seg with CLK_DIV = 4.
module tb_wb_display7seg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] adr = '0;
  logic [31:0] dat_i = '0;
  logic [31:0] dat_o;
  logic [3:0]  sel = '0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic        ack;
  logic [6:0]  segments;
  logic [3:0]  catodo;

  int vectors = 0;
  int miscompares = 0;

  wb_display7seg #(.CLK_DIV(4)) dut (
    .clk_in_1 (clk),
    .reset    (rst),
    .wb_adr_i (adr),
    .wb_dat_i (dat_i),
    .wb_dat_o (dat_o),
    .wb_sel_i (sel),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_we_i  (we),
    .wb_ack_o (ack),
    .segments (segments),
    .catodo   (catodo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wb_write(input logic [1:0] off, input logic [31:0] d,
                          input logic [3:0] s, input string tag);
    adr = {28'h0, off, 2'b00};
    dat_i = d; sel = s; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    step(1);
    chk({tag, "_ack"}, {31'h0, ack}, 32'h1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    step(1);
    chk({tag, "_ack_low"}, {31'h0, ack}, 32'h0);
  endtask

  task automatic wb_read(input logic [1:0] off, output logic [31:0] d, input string tag);
    adr = {28'h0, off, 2'b00};
    we = 1'b0; cyc = 1'b1; stb = 1'b1;
    step(1);
    chk({tag, "_ack"}, {31'h0, ack}, 32'h1);
    d = dat_o;
    cyc = 1'b0; stb = 1'b0;
    step(1);
    chk({tag, "_ack_low"}, {31'h0, ack}, 32'h0);
    chk({tag, "_hold"}, dat_o, d);
  endtask

  // Align to the first sampled cycle of a digit-0 slot.
  task automatic sync_digit0(input string tag);
    int n = 0;
    while (catodo === 4'b1110 && n < 40) begin step(1); n++; end
    while (catodo !== 4'b1110 && n < 40) begin step(1); n++; end
    chk({tag, "_sync"}, {28'h0, catodo}, 32'hE);
  endtask

  // Check 16 cycles of scan (4 per digit) and the wrap back to digit 0.
  task automatic check_scan(input logic [15:0] cats, input logic [27:0] segs, input string tag);
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("%s_cat_d%0d_c%0d", tag, d, c), {28'h0, catodo}, {28'h0, cats[d*4 +: 4]});
        chk($sformatf("%s_seg_d%0d_c%0d", tag, d, c), {25'h0, segments}, {25'h0, segs[d*7 +: 7]});
        step(1);
      end
    end
    chk({tag, "_wrap"}, {28'h0, catodo}, 32'hE);
  endtask

  initial begin
    logic [31:0] rd;
    int n;

    // Reset values, forced without a clock edge.
    #2 rst = 1'b1;
    #1;
    chk("rst_seg", {25'h0, segments}, 32'h7F);
    chk("rst_cat", {28'h0, catodo}, 32'hF);
    chk("rst_ack", {31'h0, ack}, 32'h0);
    chk("rst_dat", dat_o, 32'h0);
    step(2);
    rst = 1'b0;
    step(1);
    chk("rel_cat", {28'h0, catodo}, 32'hE);
    chk("rel_seg", {25'h0, segments}, 32'h01);
    wb_read(2'd0, rd, "rd_data_rst");
    chk("data_rst", rd, 32'h0);
    wb_read(2'd1, rd, "rd_ctrl_rst");
    chk("ctrl_rst", rd, 32'h0F);

    // Write / read-back and scan.
    wb_write(2'd0, 32'h0000_3A5F, 4'hF, "wr_3a5f");
    wb_read(2'd0, rd, "rd_3a5f");
    chk("data_3a5f", rd, 32'h0000_3A5F);
    sync_digit0("scan1");
    check_scan({4'b0111, 4'b1011, 4'b1101, 4'b1110},
               {7'h06, 7'h08, 7'h24, 7'h38}, "scan1");

    // Asynchronous reset mid-scan, with a cycle pending.
    step(2);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_seg", {25'h0, segments}, 32'h7F);
    chk("mid_rst_cat", {28'h0, catodo}, 32'hF);
    chk("mid_rst_ack", {31'h0, ack}, 32'h0);
    chk("mid_rst_dat", dat_o, 32'h0);
    step(1);
    adr = 32'h0; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    step(1);
    chk("rst_pending_ack0", {31'h0, ack}, 32'h0);
    step(1);
    chk("rst_pending_ack1", {31'h0, ack}, 32'h0);
    cyc = 1'b0; stb = 1'b0;
    rst = 1'b0;
    step(1);
    chk("rel2_cat", {28'h0, catodo}, 32'hE);
    chk("rel2_seg", {25'h0, segments}, 32'h01);
    chk("rel2_ack", {31'h0, ack}, 32'h0);
    wb_read(2'd0, rd, "rd_data_rst2");
    chk("data_rst2", rd, 32'h0);

    // Byte lanes, empty select, ignored writes, unmapped read.
    wb_write(2'd0, 32'h0000_1234, 4'hF, "wr_1234");
    wb_write(2'd0, 32'hFFFF_ABCD, 4'b0001, "wr_lane0");
    wb_read(2'd0, rd, "rd_lane0");
    chk("data_lane0", rd, 32'h0000_12CD);
    wb_write(2'd0, 32'h0000_0000, 4'h0, "wr_sel0");
    wb_read(2'd0, rd, "rd_sel0");
    chk("data_sel0", rd, 32'h0000_12CD);
    wb_write(2'd2, 32'hFFFF_FFFF, 4'hF, "wr_status");
    wb_write(2'd3, 32'hFFFF_FFFF, 4'hF, "wr_off3");
    wb_read(2'd0, rd, "rd_data_after");
    chk("data_after_ign", rd, 32'h0000_12CD);
    wb_read(2'd1, rd, "rd_ctrl_after");
    chk("ctrl_after_ign", rd, 32'h0F);
    wb_read(2'd3, rd, "rd_off3");
    chk("off3_zero", rd, 32'h0);

    // Enable mask: digits 1 and 3 dark.
    wb_write(2'd1, 32'h0000_0005, 4'hF, "wr_ctrl05");
    wb_read(2'd1, rd, "rd_ctrl05");
    chk("ctrl_05", rd, 32'h05);
    sync_digit0("scan2");
    check_scan({4'b1111, 4'b1011, 4'b1111, 4'b1110},
               {7'h7F, 7'h12, 7'h7F, 7'h42}, "scan2");

    // Blank-all.
    wb_write(2'd1, 32'h0000_001F, 4'hF, "wr_ctrl1f");
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("blank_cat_%0d", i), {28'h0, catodo}, 32'hF);
      chk($sformatf("blank_seg_%0d", i), {25'h0, segments}, 32'h7F);
      step(1);
    end

    // STATUS keeps advancing while blanked.
    n = 0;
    wb_read(2'd2, rd, "st_sync");
    while (rd !== 32'h0 && n < 10) begin
      wb_read(2'd2, rd, "st_sync");
      n++;
    end
    chk("status_0", rd, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      step(2);
      wb_read(2'd2, rd, "st_seq");
      chk($sformatf("status_seq_%0d", k), rd, 32'(k % 4));
    end

    // Held strobe: ack toggles 1,0,1,0.
    adr = 32'h0; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk($sformatf("held_ack_%0d", i), {31'h0, ack}, (i % 2 == 0) ? 32'h1 : 32'h0);
    end
    chk("held_dat", dat_o, 32'h0000_12CD);
    cyc = 1'b0; stb = 1'b0;
    step(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
